// File: rtl/phase_arb_pkg.sv
// Shared types and constants for the phase arbiter and its round-robin picker.
package phase_arb_pkg;

    // The state register is 3 bits wide. Only the four encodings below are
    // legal; any other value is treated as corruption.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3
    } state_t;

    localparam int unsigned PHASE_W = 2;
    localparam logic [PHASE_W-1:0] PHASE_WRAP = 2'd3;

    // Index width for a vector of n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next sequencer phase: 0->1->2->3->0.
    function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] p);
        return (p == PHASE_WRAP) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/phase_arbiter_if.sv
// Request/grant and sequencer-phase bundle between requesters and the arbiter.
interface phase_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
) ();
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 done;
    logic [NUM_REQ-1:0]                 grant;
    logic [phase_arb_pkg::PHASE_W-1:0]  phase;
    logic                               phase_valid;
    logic                               busy;
    logic                               timeout;
    logic                               fault;

    // Requester side.
    modport master (
        output req, done,
        input  grant, phase, phase_valid, busy, timeout, fault
    );

    // Arbiter side.
    modport slave (
        input  req, done,
        output grant, phase, phase_valid, busy, timeout, fault
    );
endinterface

// File: rtl/phase_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import phase_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan upward from the pointer and keep the first hit.
    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[IDX_W'(idx)]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/phase_arbiter.sv
// Round-robin owner arbitration for the shared 4-phase sequencer. The owner
// gets the sequencer for a bounded number of RUN cycles; illegal state
// encodings fall back to IDLE and latch a sticky fault.
module phase_arbiter
    import phase_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    phase_arbiter_if.slave  bus
);

    localparam int unsigned OWN_W  = idx_width(NUM_REQ);
    localparam int unsigned HOLD_W = idx_width(HOLD_MAX);

    state_t               state_q, state_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 phase_valid_q, phase_valid_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic                 fault_q, fault_d;

    logic [OWN_W-1:0]     winner;
    logic                 win_valid;
    logic                 owner_done;
    logic                 owner_req;
    logic                 hold_limit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    assign owner_done = bus.done[owner_q];
    assign owner_req  = bus.req[owner_q];
    assign hold_limit = (hold_cnt_q == HOLD_W'(HOLD_MAX - 1));

    // Next state and next registered outputs; outputs are computed for the
    // state being entered so they line up with it after the edge.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = '0;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        busy_d        = 1'b0;
        timeout_d     = 1'b0;
        fault_d       = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    owner_d    = winner;
                    state_d    = ST_GRANT;
                    grant_d    = NUM_REQ'(1) << winner;
                    phase_d    = '0;
                    hold_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_GRANT: begin
                state_d       = ST_RUN;
                grant_d       = NUM_REQ'(1) << owner_q;
                phase_d       = '0;
                phase_valid_d = 1'b1;
                hold_cnt_d    = '0;
                busy_d        = 1'b1;
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (owner_done || !owner_req || hold_limit) begin
                    state_d   = ST_RELEASE;
                    timeout_d = hold_limit && !owner_done;
                end else begin
                    grant_d       = NUM_REQ'(1) << owner_q;
                    phase_valid_d = 1'b1;
                    phase_d       = phase_step(phase_q);
                    hold_cnt_d    = hold_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                fault_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.busy        = busy_q;
    assign bus.timeout     = timeout_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Directed scoreboard bench for phase_arbiter.
module tb_phase_arbiter;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned HOLD_MAX = 8;

    typedef struct {
        string              tag;
        logic [NUM_REQ-1:0] grant;
        logic [1:0]         phase;
        logic               pv;
        logic               busy;
        logic               timeout;
        logic               fault;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    phase_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    phase_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [NUM_REQ-1:0] g, input logic [1:0] ph,
                        input logic pv, input logic bz, input logic to, input logic ft);
        exp_t e;
        e.tag = tag; e.grant = g; e.phase = ph; e.pv = pv;
        e.busy = bz; e.timeout = to; e.fault = ft;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic [NUM_REQ+5:0] got;
        logic [NUM_REQ+5:0] want;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow: got no expected entry, required one");
            return;
        end
        e    = sb.pop_front();
        got  = {bus_if.grant, bus_if.phase, bus_if.phase_valid, bus_if.busy, bus_if.timeout, bus_if.fault};
        want = {e.grant, e.phase, e.pv, e.busy, e.timeout, e.fault};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got grant=%b phase=%0d pv=%b busy=%b timeout=%b fault=%b, want grant=%b phase=%0d pv=%b busy=%b timeout=%b fault=%b",
                   e.tag, bus_if.grant, bus_if.phase, bus_if.phase_valid, bus_if.busy, bus_if.timeout, bus_if.fault,
                   e.grant, e.phase, e.pv, e.busy, e.timeout, e.fault);
        end
    endtask

    // Drive inputs for one cycle, record the expected post-edge outputs, then sample.
    task automatic tick(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] d, input string tag,
                        input logic [NUM_REQ-1:0] g, input logic [1:0] ph,
                        input logic pv, input logic bz, input logic to, input logic ft);
        bus_if.req  = r;
        bus_if.done = d;
        push(tag, g, ph, pv, bz, to, ft);
        @(posedge clk);
        #1;
        check_now();
    endtask

    // Asynchronous reset pulse starting just after an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        push(tag, '0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_now();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NUM_REQ-1:0] o;
        vectors     = 0;
        miscompares = 0;
        bus_if.req  = '0;
        bus_if.done = '0;
        rst_n       = 1'b1;
        #1;
        rst_n = 1'b0;
        push("reset", '0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_now();
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, done in the third RUN cycle.
        tick(3'b001, 3'b000, "single_grant", 3'b001, 2'd0, 0, 1, 0, 0);
        tick(3'b001, 3'b000, "single_run0",  3'b001, 2'd0, 1, 1, 0, 0);
        tick(3'b001, 3'b000, "single_run1",  3'b001, 2'd1, 1, 1, 0, 0);
        tick(3'b001, 3'b000, "single_run2",  3'b001, 2'd2, 1, 1, 0, 0);
        tick(3'b001, 3'b001, "single_rel",   3'b000, 2'd2, 0, 1, 0, 0);
        tick(3'b000, 3'b000, "single_idle",  3'b000, 2'd2, 0, 0, 0, 0);
        do_reset("reset_mid");

        // Round robin with all requesting; each owner finishes after one RUN cycle.
        for (int k = 0; k < 4; k++) begin
            o = NUM_REQ'(1) << (k % NUM_REQ);
            tick(3'b111, 3'b000, "rr_grant", o,      2'd0, 0, 1, 0, 0);
            tick(3'b111, 3'b000, "rr_run",   o,      2'd0, 1, 1, 0, 0);
            tick(3'b111, o,      "rr_rel",   3'b000, 2'd0, 0, 1, 0, 0);
            tick(3'b111, 3'b000, "rr_idle",  3'b000, 2'd0, 0, 0, 0, 0);
        end

        // Forced release after HOLD_MAX RUN cycles.
        tick(3'b010, 3'b000, "to_grant", 3'b010, 2'd0, 0, 1, 0, 0);
        for (int k = 0; k < HOLD_MAX; k++) begin
            tick(3'b010, 3'b000, "to_run", 3'b010, 2'(k % 4), 1, 1, 0, 0);
        end
        tick(3'b010, 3'b000, "to_rel",  3'b000, 2'd3, 0, 1, 1, 0);
        tick(3'b000, 3'b000, "to_idle", 3'b000, 2'd3, 0, 0, 0, 0);

        // done coincident with the hold limit: no timeout.
        tick(3'b100, 3'b000, "col_grant", 3'b100, 2'd0, 0, 1, 0, 0);
        for (int k = 0; k < HOLD_MAX; k++) begin
            tick(3'b100, 3'b000, "col_run", 3'b100, 2'(k % 4), 1, 1, 0, 0);
        end
        tick(3'b100, 3'b100, "col_rel",  3'b000, 2'd3, 0, 1, 0, 0);
        tick(3'b000, 3'b000, "col_idle", 3'b000, 2'd3, 0, 0, 0, 0);

        // Non-owner done ignored, then abandon by the owner.
        tick(3'b001, 3'b000, "ab_grant",  3'b001, 2'd0, 0, 1, 0, 0);
        tick(3'b001, 3'b000, "ab_run0",   3'b001, 2'd0, 1, 1, 0, 0);
        tick(3'b001, 3'b010, "ab_nodone", 3'b001, 2'd1, 1, 1, 0, 0);
        tick(3'b000, 3'b000, "ab_rel",    3'b000, 2'd1, 0, 1, 0, 0);
        tick(3'b000, 3'b000, "ab_idle",   3'b000, 2'd1, 0, 0, 0, 0);

        // Asynchronous reset mid-RUN; pointer returns to 0.
        tick(3'b011, 3'b000, "ar_grant", 3'b010, 2'd0, 0, 1, 0, 0);
        tick(3'b011, 3'b000, "ar_run0",  3'b010, 2'd0, 1, 1, 0, 0);
        tick(3'b011, 3'b000, "ar_run1",  3'b010, 2'd1, 1, 1, 0, 0);
        do_reset("reset_async_run");
        tick(3'b111, 3'b000, "ar_regrant", 3'b001, 2'd0, 0, 1, 0, 0);
        tick(3'b111, 3'b000, "ar_run",     3'b001, 2'd0, 1, 1, 0, 0);
        tick(3'b000, 3'b000, "ar_rel",     3'b000, 2'd0, 0, 1, 0, 0);
        tick(3'b000, 3'b000, "ar_idle",    3'b000, 2'd0, 0, 0, 0, 0);

        // Illegal state encoding mid-RUN.
        tick(3'b001, 3'b000, "il_grant", 3'b001, 2'd0, 0, 1, 0, 0);
        tick(3'b001, 3'b000, "il_run0",  3'b001, 2'd0, 1, 1, 0, 0);
        bus_if.req  = 3'b000;
        bus_if.done = 3'b000;
        force dut.state_q = phase_arb_pkg::state_t'(3'd5);
        push("il_detect", 3'b000, 2'd0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        release dut.state_q;
        check_now();
        tick(3'b000, 3'b000, "il_idle",   3'b000, 2'd0, 0, 0, 0, 1);
        tick(3'b001, 3'b000, "il_sticky", 3'b001, 2'd0, 0, 1, 0, 1);
        do_reset("reset_clears_fault");
        tick(3'b000, 3'b000, "post_reset_idle", 3'b000, 2'd0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
